// File: rtl/dmem_pkg.sv
// dmem_pkg: size-mask encodings, responder states and size decode shared by the data-memory responder
package dmem_pkg;

    localparam logic [2:0] MASK_B = 3'b000;
    localparam logic [2:0] MASK_H = 3'b001;
    localparam logic [2:0] MASK_W = 3'b011;
    localparam logic [2:0] MASK_D = 3'b111;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] mask);
        return mask[2] ? 4'd8 : mask[1] ? 4'd4 : mask[0] ? 4'd2 : 4'd1;
    endfunction

endpackage

// File: rtl/dmem_lane_shift.sv
// dmem_lane_shift: byte enables, write-data alignment and read shift amount for one beat of an access
module dmem_lane_shift (
    input  logic [2:0]  off,
    input  logic [3:0]  n,
    input  logic        beat,
    input  logic [63:0] wdata,
    output logic [7:0]  byte_en,
    output logic [63:0] wdata_sh,
    output logic [6:0]  rd_sh
);
    logic [15:0] span;
    // span covers both doublewords; beat 1 takes the part that spilled past byte 7
    assign span     = ((16'd1 << n) - 16'd1) << off;
    assign byte_en  = beat ? span[15:8] : span[7:0];
    assign rd_sh    = beat ? 7'd64 - {1'b0, off, 3'b0} : {1'b0, off, 3'b0};
    assign wdata_sh = beat ? wdata >> rd_sh : wdata << rd_sh;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: 64-bit data array with unaligned byte/half/word/dword access, split into two beats when crossing
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_mask,
    input  logic [N-1:0]  req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_rdata,
    output logic          rsp_err
);
    localparam int MAW = $clog2(DEPTH);
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH * 8);

    state_t state_q, state_d;
    logic we_q, we_d, cross_q, cross_d, err_q, err_d;
    logic [2:0] off_q, off_d;
    logic [3:0] n_q, n_d, req_n;
    logic [MAW-1:0] dw_q, dw_d, idx;
    logic [N-1:0] wdata_q, wdata_d, acc_q, acc_d, rd_q, lo, hi, wdata_sh;
    logic [N-1:0] mem [DEPTH];
    logic [7:0] byte_en;
    logic [6:0] rd_sh;
    logic beat, acc;

    assign req_n = size_bytes(req_mask);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        cross_d = cross_q;
        err_d   = err_q;
        off_d   = off_q;
        n_d     = n_q;
        dw_d    = dw_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = ACC0;
                we_d    = req_we;
                off_d   = req_addr[2:0];
                dw_d    = req_addr[MAW+2:3];
                n_d     = req_n;
                wdata_d = req_wdata;
                cross_d = ({1'b0, req_addr[2:0]} + req_n) > 4'd8;
                err_d   = ({1'b0, req_addr} + (AW+1)'(req_n) - (AW+1)'(1)) >= LIMIT;
            end
            ACC0: state_d = cross_q ? ACC1 : RESP;
            ACC1: begin
                acc_d   = rd_q;
                state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
            off_q   <= '0;
            n_q     <= '0;
            dw_q    <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            cross_q <= cross_d;
            err_q   <= err_d;
            off_q   <= off_d;
            n_q     <= n_d;
            dw_q    <= dw_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
        end
    end

    // beat 1 stays selected in RESP so the shared shifter supplies the upper-beat read shift
    assign beat = (state_q == ACC1) || (state_q == RESP);
    assign acc  = (state_q == ACC0) || (state_q == ACC1);
    assign idx  = dw_q + MAW'(state_q == ACC1);

    dmem_lane_shift u_lane (
        .off      (off_q),
        .n        (n_q),
        .beat     (beat),
        .wdata    (wdata_q),
        .byte_en  (byte_en),
        .wdata_sh (wdata_sh),
        .rd_sh    (rd_sh)
    );

    // plain registered read plus byte-enabled write keeps the array block-RAM shaped
    always_ff @(posedge clk) begin
        if (acc) begin
            rd_q <= mem[idx];
            for (int i = 0; i < 8; i++)
                if (we_q && !err_q && byte_en[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
    end

    assign lo        = cross_q ? acc_q : rd_q;
    assign hi        = cross_q ? rd_q : '0;
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ?
                       ((lo >> {off_q, 3'b0}) | (hi << rd_sh)) & ~({N{1'b1}} << {n_q, 3'b0}) : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, corner sequences and random traffic against a byte-array model
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [15:0] req_addr = 0;
    logic [2:0]  req_mask = 0;
    logic [63:0] req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;

    int n_chk = 0, n_fail = 0;
    logic [7:0] model [8192];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [2:0]  mask;
        logic [63:0] wd;
        logic [63:0] rd;
        logic        err;
        int          lat;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] mask);
        return mask == MASK_D ? 8 : mask == MASK_W ? 4 : mask == MASK_H ? 2 : 1;
    endfunction

    function automatic void mdl_store(input int addr, input int n, input logic [63:0] wd);
        for (int i = 0; i < n; i++) model[addr+i] = wd[8*i +: 8];
    endfunction

    function automatic logic [63:0] mdl_load(input int addr, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r |= 64'(model[addr+i]) << (8*i);
        return r;
    endfunction

    task automatic xact(input logic we, input logic [15:0] addr, input logic [2:0] mask,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er, output int lat);
        int t = 0;
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = addr; req_mask = mask; req_wdata = wd;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 req_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    task automatic run(input string name, input logic we, input logic [15:0] addr, input logic [2:0] mask,
                       input logic [63:0] wd, input logic [63:0] erd, input logic eerr, input int elat);
        logic [63:0] rd; logic er; int lat;
        xact(we, addr, mask, wd, rd, er, lat);
        chk({name, "_rdata"}, rd, erd);
        chk({name, "_err"}, 64'(er), 64'(eerr));
        chk({name, "_lat"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rd, bp_exp;
        logic er;
        int lat, t;
        logic [2:0] mk [4] = '{MASK_B, MASK_H, MASK_W, MASK_D};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        rst_n = 1;

        tbl.push_back('{1, 16'h0040, MASK_D, 64'h1122334455667788, 64'h0, 0, 2});
        tbl.push_back('{0, 16'h0040, MASK_D, 64'h0, 64'h1122334455667788, 0, 2});
        tbl.push_back('{1, 16'h0045, MASK_B, 64'hFFFFFFFFFFFFFFAB, 64'h0, 0, 2});
        tbl.push_back('{0, 16'h0040, MASK_D, 64'h0, 64'h1122AB4455667788, 0, 2});
        tbl.push_back('{0, 16'h0044, MASK_H, 64'h0, 64'h000000000000AB44, 0, 2});
        tbl.push_back('{1, 16'h0100, MASK_D, 64'h0706050403020100, 64'h0, 0, 2});
        tbl.push_back('{1, 16'h0108, MASK_D, 64'h0F0E0D0C0B0A0908, 64'h0, 0, 2});
        tbl.push_back('{1, 16'h0106, MASK_W, 64'h00000000DEADBEEF, 64'h0, 0, 3});
        tbl.push_back('{0, 16'h0106, MASK_W, 64'h0, 64'h00000000DEADBEEF, 0, 3});
        tbl.push_back('{0, 16'h0105, MASK_B, 64'h0, 64'h05, 0, 2});
        tbl.push_back('{0, 16'h010A, MASK_B, 64'h0, 64'h0A, 0, 2});
        tbl.push_back('{0, 16'h0100, MASK_D, 64'h0, 64'hBEEF050403020100, 0, 2});
        tbl.push_back('{0, 16'h0108, MASK_D, 64'h0, 64'h0F0E0D0C0B0ADEAD, 0, 2});
        tbl.push_back('{1, 16'h1FF8, MASK_D, 64'hA5A5A5A5A5A5A5A5, 64'h0, 0, 2});
        tbl.push_back('{1, 16'h1FFE, MASK_W, 64'h0000000012345678, 64'h0, 1, 3});
        tbl.push_back('{0, 16'h1FF8, MASK_D, 64'h0, 64'hA5A5A5A5A5A5A5A5, 0, 2});
        tbl.push_back('{0, 16'h1FFE, MASK_W, 64'h0, 64'h0, 1, 3});
        tbl.push_back('{0, 16'h2000, MASK_B, 64'h0, 64'h0, 1, 2});
        tbl.push_back('{0, 16'h1FFF, MASK_B, 64'h0, 64'hA5, 0, 2});
        tbl.push_back('{0, 16'h1FFF, MASK_H, 64'h0, 64'h0, 1, 3});
        tbl.push_back('{1, 16'h0044, MASK_H, 64'hFFFFFFFFFFFF1234, 64'h0, 0, 2});
        tbl.push_back('{0, 16'h0040, MASK_D, 64'h0, 64'h1122123455667788, 0, 2});
        foreach (tbl[i])
            run($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].mask, tbl[i].wd,
                tbl[i].rd, tbl[i].err, tbl[i].lat);

        // backpressure: response held for 5 cycles while a stray store request is offered
        bp_exp = 64'h1122123455667788;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 16'h0040; req_mask = MASK_D;
        @(posedge clk);
        #1 req_valid = 0;
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid%0d", c), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp_rdata%0d", c), rsp_rdata, bp_exp);
            chk($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
            req_valid = (c == 2); req_we = 1; req_wdata = 64'h0;
            @(negedge clk);
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        chk("bp_after_valid", 64'(rsp_valid), 64'd0);
        run("bp_reload", 0, 16'h0040, MASK_D, 64'h0, bp_exp, 0, 2);

        // preload the random windows so every in-range load has a known value
        for (int a = 0; a < 'h400; a += 8) begin
            rd = {$urandom, $urandom};
            mdl_store(a, 8, rd);
            run("pre_lo", 1, 16'(a), MASK_D, rd, 64'h0, 0, 2);
        end
        for (int a = 'h1FC0; a < 'h2000; a += 8) begin
            rd = {$urandom, $urandom};
            mdl_store(a, 8, rd);
            run("pre_hi", 1, 16'(a), MASK_D, rd, 64'h0, 0, 2);
        end

        for (int k = 0; k < 300; k++) begin
            logic we, e;
            logic [2:0] m;
            logic [15:0] a;
            logic [63:0] wd, erd;
            int n;
            we = 1'($urandom % 2);
            m  = mk[$urandom % 4];
            n  = nbytes(m);
            a  = ($urandom % 5 == 0) ? 16'(16'h1FC0 + $urandom % 'h60) : 16'($urandom_range(0, 'h3F0));
            wd = {$urandom, $urandom};
            e  = (int'(a) + n - 1) >= 8192;
            erd = (we || e) ? 64'h0 : mdl_load(int'(a), n);
            if (we && !e) mdl_store(int'(a), n, wd);
            run($sformatf("rnd%0d", k), we, a, m, wd, erd, e, (int'(a[2:0]) + n > 8) ? 3 : 2);
        end

        // reset while the second beat of a crossing store is pending
        run("mx_pre0", 1, 16'h0200, MASK_D, 64'h1111111111111111, 64'h0, 0, 2);
        run("mx_pre1", 1, 16'h0208, MASK_D, 64'h2222222222222222, 64'h0, 0, 2);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 16'h0204; req_mask = MASK_D; req_wdata = 64'h8877665544332211;
        @(posedge clk);
        #1 req_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mx_busy_ready", 64'(req_ready), 64'd0);
        rst_n = 0;
        #1;
        chk("mx_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mx_rst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1;
        run("mx_beat0", 0, 16'h0200, MASK_D, 64'h0, 64'h4433221111111111, 0, 2);
        run("mx_beat1", 0, 16'h0208, MASK_D, 64'h0, 64'h2222222222222222, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that sits behind the memory-stage masking logic.
- Accepts byte/half/word/doubleword load and store requests, using the codebase's thermometer size mask, over a valid/ready handshake.
- Holds the 64-bit storage array and performs byte-lane alignment of read and write data.
- Splits accesses that cross a doubleword boundary into two array beats and returns one response per request.

Parameters:
- N, 64, data width in bits; fixed at 64, other values unsupported.
- DEPTH, 1024, number of N-bit doublewords in the array.
- AW, 16, byte-address width; legal byte range is 0 .. DEPTH*8-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AW  byte address; any alignment allowed.
- req_mask  in  3  size mask: 000 = byte, 001 = half, 011 = word, 111 = dword.
- req_wdata  in  N  store data, right-justified; bytes above the access size are ignored.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  N  load data, right-justified, zero above the access size; 0 for stores and errors.
- rsp_err  out  1  access out of range.

Behaviour:
- Reset values (while rst_n low):
  - state = IDLE.
  - req_ready = 1, since it is decoded from state.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Array contents are not reset.
- Definitions:
  - Access size n = 1/2/4/8 bytes, from req_mask.
  - off = addr[2:0], dw = addr[AW-1:3].
  - The access crosses a doubleword boundary iff off + n > 8.
- Error: raised if any byte of the access is >= DEPTH*8, including a crossing access that runs past the top of the array. On error:
  - No array write.
  - rsp_err = 1, rsp_rdata = 0.
  - Same latency as a legal access.
- State machine: IDLE -> ACC0 -> (ACC1 if crossing) -> RESP -> IDLE.
  - IDLE: req_ready = 1. On handshake, latch we/addr/mask/wdata and the crossing/error flags; go to ACC0.
  - ACC0: access array[dw].
    - Store: write bytes off .. min(7, off+n-1) with (wdata << 8*off).
    - Load: capture (array[dw] >> 8*off).
    - Then go to ACC1 if crossing, else RESP.
  - ACC1: access array[dw+1].
    - Store: write bytes 0 .. off+n-9 with (wdata >> 8*(8-off)).
    - Load: OR (array[dw+1] << 8*(8-off)) into the captured data.
    - Then go to RESP.
  - RESP: rsp_valid = 1; rsp_rdata is masked to n bytes. rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready. On handshake go to IDLE with rsp_valid = 0.
- req_ready = 0 outside IDLE; one request is outstanding at a time.
- Latency, with the accept edge as cycle 0: rsp_valid rises in cycle 2 for a non-crossing access and cycle 3 for a crossing access.
- Loads see all stores whose responses have already been issued.
- Sign extension is not done here; that stays in memory-stage logic.
- Reset mid-operation returns to IDLE immediately and drops any pending response. A crossing store interrupted after ACC0 leaves beat 0 written and beat 1 unwritten; this is accepted behaviour.
- Array read is synchronous on the clk edge in ACC0/ACC1, so it maps to block RAM.
- Write uses per-byte enables on the same edge, read-before-write within an access.

Decomposition:
- Package dmem_pkg holds:
  - Mask constants MASK_B = 3'b000, MASK_H = 3'b001, MASK_W = 3'b011, MASK_D = 3'b111.
  - State enum {IDLE, ACC0, ACC1, RESP}.
  - Function size_bytes(mask) -> 4-bit count.
- One combinational sub-module, dmem_lane_shift, takes (off, n, beat, wdata) and produces (byte_en[7:0], wdata_shifted, read shift amount). It is instanced once and shared by both beats.

Test Plan:
- Aligned dword: store 0x1122334455667788 at 0x40, then dword load at 0x40 -> rsp_rdata = 0x1122334455667788, rsp_err = 0, rsp_valid in cycle 2.
- Sub-word store:
  - Byte store 0xAB at 0x45 over that dword -> dword load at 0x40 = 0x1122AB4455667788.
  - Half load at 0x44 -> 0x0000_0000_0000_AB44.
- Crossing word: store 0xDEADBEEF at 0x106 -> bytes 0x106..0x109 = EF, BE, AD, DE.
  - Word load at 0x106 -> 0xDEADBEEF with rsp_valid in cycle 3.
  - Neighbouring bytes 0x105 and 0x10A unchanged.
- Range: DEPTH = 1024, word store at 0x1FFE -> rsp_err = 1, no array change; dword load at 0x1FF8 -> rsp_err = 0.
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready = 0 throughout; a req_valid pulse in that window is not accepted.
- Reset mid-crossing: assert rst_n = 0 in ACC1 of a crossing store -> state IDLE, rsp_valid = 0 asynchronously; afterwards beat-0 bytes written, beat-1 bytes unchanged.
